// File: rtl/axi_apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB4 requester.
package axi_apb_pkg;

  // Transaction sequencing: address capture, write data capture, APB setup,
  // APB access, then holding the AXI response until it is taken.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/apb_watchdog.sv
// Counts APB access cycles spent waiting for pready and flags when the
// limit is hit. A limit of 0 keeps the counter idle and never expires.
module apb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int  CntWidth = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit  Enabled  = (TIMEOUT_CYCLES > 0);
  localparam logic [CntWidth-1:0] Last = CntWidth'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Next count: clear on request, otherwise step while waiting, saturating at the limit.
  always_comb begin
    // NOTE: assign the default before any branch so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (Enabled && en_i && (cnt_q != Last)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: nonblocking assignments here so every flop samples the pre-edge values.
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle that would take the count to the limit is the last one tolerated.
  assign expired_o = Enabled && en_i && (cnt_q == Last);

endmodule

// File: rtl/axi4lite_apb_requester.sv
// AXI4-Lite responder that turns each accepted transaction into one APB4
// transfer. One transaction at a time, writes win ties, access phase guarded
// by a watchdog.
module axi4lite_apb_requester
  import axi_apb_pkg::*;
#(
  parameter int dataWidth      = 32,
  parameter int addrWidth      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   awvalid,
  input  logic [addrWidth-1:0]   awaddr,
  input  logic [2:0]             awprot,
  output logic                   awready,
  input  logic                   wvalid,
  input  logic [dataWidth-1:0]   wdata,
  input  logic [dataWidth/8-1:0] wstrb,
  output logic                   wready,
  output logic                   bvalid,
  output logic [1:0]             bresp,
  input  logic                   bready,
  input  logic                   arvalid,
  input  logic [addrWidth-1:0]   araddr,
  input  logic [2:0]             arprot,
  output logic                   arready,
  output logic                   rvalid,
  output logic [dataWidth-1:0]   rdata,
  output logic [1:0]             rresp,
  input  logic                   rready,
  output logic [addrWidth-1:0]   paddr,
  output logic [2:0]             pprot,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [dataWidth-1:0]   pwdata,
  output logic [dataWidth/8-1:0] pstrb,
  input  logic [dataWidth-1:0]   prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  state_e                   state_q, state_d;
  logic [addrWidth-1:0]     paddr_q, paddr_d;
  logic [2:0]               pprot_q, pprot_d;
  logic                     pwrite_q, pwrite_d;
  logic [dataWidth-1:0]     pwdata_q, pwdata_d;
  logic [dataWidth/8-1:0]   pstrb_q, pstrb_d;
  logic [dataWidth-1:0]     rdata_q, rdata_d;
  logic [1:0]               resp_q, resp_d;
  logic                     wd_expired;

  apb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == SETUP),
    .en_i      ((state_q == ACCESS) && !pready),
    .expired_o (wd_expired)
  );

  // Next-state and register updates for the transaction sequencer.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pprot_d  = pprot_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    resp_d   = resp_q;
    case (state_q)
      IDLE: begin
        if (awvalid) begin
          paddr_d  = awaddr;
          pprot_d  = awprot;
          pwrite_d = 1'b1;
          state_d  = WDATA;
        end else if (arvalid) begin
          paddr_d  = araddr;
          pprot_d  = arprot;
          pwrite_d = 1'b0;
          pstrb_d  = '0;
          state_d  = SETUP;
        end
      end
      WDATA: begin
        if (wvalid) begin
          pwdata_d = wdata;
          pstrb_d  = wstrb;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          resp_d = pslverr ? RESP_SLVERR : RESP_OKAY;
          if (!pwrite_q) rdata_d = prdata;
          state_d = RESP;
        end else if (wd_expired) begin
          resp_d = RESP_SLVERR;
          if (!pwrite_q) rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (pwrite_q ? bready : rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pprot_q  <= pprot_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
    end
  end

  // Handshake and APB phase signals decode straight from the state register.
  assign awready = (state_q == IDLE);
  assign arready = (state_q == IDLE) && !awvalid;
  assign wready  = (state_q == WDATA);
  assign psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign penable = (state_q == ACCESS);
  assign bvalid  = (state_q == RESP) && pwrite_q;
  assign rvalid  = (state_q == RESP) && !pwrite_q;
  assign bresp   = bvalid ? resp_q : RESP_OKAY;
  assign rresp   = rvalid ? resp_q : RESP_OKAY;
  assign rdata   = rdata_q;
  assign paddr   = paddr_q;
  assign pprot   = pprot_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign pstrb   = pstrb_q;

endmodule

// File: tb/tb_axi4lite_apb_requester.sv
// Directed bench for the AXI4-Lite to APB requester. A second instance with
// the watchdog disabled shares all inputs.
module tb_axi4lite_apb_requester;

  logic        clk, rst;
  logic        awvalid, wvalid, bready, arvalid, rready, pready, pslverr;
  logic [31:0] awaddr, wdata, araddr, prdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;

  logic        awready, wready, bvalid, arready, rvalid, psel, penable, pwrite;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;

  logic        awready_z, wready_z, bvalid_z, arready_z, rvalid_z, psel_z, penable_z, pwrite_z;
  logic [1:0]  bresp_z, rresp_z;
  logic [31:0] rdata_z, paddr_z, pwdata_z;
  logic [2:0]  pprot_z;
  logic [3:0]  pstrb_z;

  int checks = 0;
  int errors = 0;
  int n_access;

  axi4lite_apb_requester #(.dataWidth(32), .addrWidth(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  axi4lite_apb_requester #(.dataWidth(32), .addrWidth(32), .TIMEOUT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready_z),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready_z),
    .bvalid(bvalid_z), .bresp(bresp_z), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready_z),
    .rvalid(rvalid_z), .rdata(rdata_z), .rresp(rresp_z), .rready(rready),
    .paddr(paddr_z), .pprot(pprot_z), .psel(psel_z), .penable(penable_z), .pwrite(pwrite_z),
    .pwdata(pwdata_z), .pstrb(pstrb_z), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    awvalid = 0; awaddr = '0; awprot = '0; wvalid = 0; wdata = '0; wstrb = '0;
    bready = 0; arvalid = 0; araddr = '0; arprot = '0; rready = 0;
    prdata = '0; pready = 0; pslverr = 0;
    #1 rst = 1'b0;
    #2;
    // Reset state
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_psel", {psel, penable, pwrite, wready, bvalid, rvalid}, 0);
    check("rst_paddr", paddr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_resp", {bresp, rresp}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Write 0x10 <- 0xDEADBEEF, pready in the first access cycle
    cyc();
    awvalid = 1; awaddr = 32'h10; awprot = 3'd2;
    #1 check("wr_awready", awready, 1);
    cyc();                              // cycle 1: WDATA
    awvalid = 0;
    wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    check("wr_wready", wready, 1);
    check("wr_c1_psel", psel, 0);
    cyc();                              // cycle 2: SETUP
    wvalid = 0; pready = 1;
    check("wr_setup_sel_en", {psel, penable}, 2'b10);
    check("wr_setup_pwrite", pwrite, 1);
    check("wr_setup_pstrb", pstrb, 4'hF);
    check("wr_setup_paddr", paddr, 32'h10);
    check("wr_setup_pprot", pprot, 3'd2);
    check("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    cyc();                              // cycle 3: ACCESS
    check("wr_access_sel_en", {psel, penable}, 2'b11);
    check("wr_c3_bvalid", bvalid, 0);
    cyc();                              // cycle 4: RESP
    pready = 0;
    check("wr_bvalid", bvalid, 1);
    check("wr_bresp", bresp, 2'b00);
    check("wr_resp_psel", psel, 0);
    check("wr_rvalid", rvalid, 0);
    bready = 1;
    cyc();
    bready = 0;
    check("wr_done_bvalid", bvalid, 0);
    check("wr_done_awready", awready, 1);

    // Read 0x20 with three wait states
    arvalid = 1; araddr = 32'h20; arprot = 3'd1;
    #1 check("rd_arready", arready, 1);
    cyc();                              // SETUP
    arvalid = 0;
    check("rd_setup_sel_en", {psel, penable}, 2'b10);
    check("rd_setup_pwrite", pwrite, 0);
    check("rd_setup_pstrb", pstrb, 0);
    check("rd_setup_paddr", paddr, 32'h20);
    n_access = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (penable) n_access++;
      check("rd_wait_paddr", paddr, 32'h20);
      if (i == 3) begin
        pready = 1; prdata = 32'h12345678;
      end
    end
    cyc();                              // RESP
    pready = 0;
    check("rd_penable_cycles", n_access, 4);
    check("rd_rvalid", rvalid, 1);
    check("rd_rdata", rdata, 32'h12345678);
    check("rd_rresp", rresp, 2'b00);
    check("rd_bvalid", bvalid, 0);
    rready = 1;
    cyc();
    rready = 0;

    // Simultaneous aw and ar: write first, read after bready
    awvalid = 1; awaddr = 32'h40; arvalid = 1; araddr = 32'h30;
    #1 check("tie_arready", arready, 0);
    check("tie_awready", awready, 1);
    cyc();                              // WDATA
    awvalid = 0;
    wvalid = 1; wdata = 32'hA5A50001; wstrb = 4'h3;
    check("tie_wdata_arready", arready, 0);
    cyc();                              // SETUP
    wvalid = 0; pready = 1; prdata = 32'hCAFE0030;
    check("tie_setup_pwrite", pwrite, 1);
    check("tie_setup_paddr", paddr, 32'h40);
    check("tie_setup_pstrb", pstrb, 4'h3);
    cyc();                              // ACCESS
    cyc();                              // RESP
    check("tie_bvalid", bvalid, 1);
    check("tie_resp_arready", arready, 0);
    cyc();                              // still RESP, bready low
    check("tie_hold_psel", psel, 0);
    check("tie_hold_bvalid", bvalid, 1);
    bready = 1;
    cyc();                              // IDLE
    bready = 0;
    #1 check("tie_idle_arready", arready, 1);
    cyc();                              // SETUP of the read
    arvalid = 0;
    check("tie_rd_paddr", paddr, 32'h30);
    check("tie_rd_pwrite", pwrite, 0);
    cyc();                              // ACCESS
    cyc();                              // RESP
    pready = 0;
    check("tie_rd_rvalid", rvalid, 1);
    check("tie_rd_rdata", rdata, 32'hCAFE0030);
    rready = 1;
    cyc();
    rready = 0;

    // Read with pslverr
    arvalid = 1; araddr = 32'h50;
    cyc();                              // SETUP
    arvalid = 0; pready = 1; pslverr = 1; prdata = 32'hBAD0BAD0;
    cyc();                              // ACCESS
    cyc();                              // RESP
    pready = 0; pslverr = 0;
    check("err_rresp", rresp, 2'b10);
    check("err_rdata", rdata, 32'hBAD0BAD0);
    rready = 1;
    cyc();
    rready = 0;

    // Write with bready held low for 5 cycles
    awvalid = 1; awaddr = 32'h60;
    cyc();
    awvalid = 0; wvalid = 1; wdata = 32'h11223344; wstrb = 4'hC;
    cyc();                              // SETUP
    wvalid = 0; pready = 1;
    cyc();                              // ACCESS
    cyc();                              // RESP
    pready = 0;
    for (int i = 0; i < 5; i++) begin
      check("hold_bvalid", bvalid, 1);
      check("hold_bresp", bresp, 2'b00);
      check("hold_psel", psel, 0);
      cyc();
    end
    check("hold_rdata_kept", rdata, 32'hBAD0BAD0);
    bready = 1;
    cyc();
    bready = 0;
    check("hold_done", bvalid, 0);

    // Watchdog: pready never arrives
    awvalid = 1; awaddr = 32'h70;
    cyc();
    awvalid = 0; wvalid = 1; wdata = 32'h0; wstrb = 4'hF;
    cyc();                              // SETUP
    wvalid = 0;
    n_access = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (psel && penable) n_access++;
      else break;
    end
    check("to_access_cycles", n_access, 16);
    check("to_psel", psel, 0);
    check("to_bvalid", bvalid, 1);
    check("to_bresp", bresp, 2'b10);
    check("to_off_still_access", {psel_z, penable_z}, 2'b11);
    check("to_off_bvalid", bvalid_z, 0);
    bready = 1;
    cyc();
    bready = 0;

    // Reset during ACCESS
    arvalid = 1; araddr = 32'h80;
    cyc();                              // SETUP
    arvalid = 0;
    cyc();                              // ACCESS
    check("rst_pre_penable", penable, 1);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_sel_en", {psel, penable, bvalid, rvalid}, 0);
    check("rst_mid_off_sel_en", {psel_z, penable_z, bvalid_z, rvalid_z}, 0);
    check("rst_mid_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b1;

    // Read after reset completes normally
    cyc();
    arvalid = 1; araddr = 32'h90;
    #1 check("post_arready", arready, 1);
    cyc();                              // SETUP
    arvalid = 0; pready = 1; prdata = 32'h0BADF00D;
    check("post_paddr", paddr, 32'h90);
    cyc();                              // ACCESS
    cyc();                              // RESP
    pready = 0;
    check("post_rvalid", rvalid, 1);
    check("post_rdata", rdata, 32'h0BADF00D);
    check("post_rresp", rresp, 2'b00);
    check("post_off_rdata", rdata_z, 32'h0BADF00D);
    rready = 1;
    cyc();
    rready = 0;
    check("post_idle", {rvalid, awready}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4lite_apb_requester.md
Name: axi4lite_apb_requester

Overview:
Other end of the AXI4-Lite transactor's master-side port: acts as the AXI4-Lite responder for those forwarded aw/w/ar/b/r channels and converts each transaction into one APB4 transfer. Sits between the transactor and the APB peripheral fabric of the apb-axi4lite bridge. One transaction in flight at a time, with write priority and a watchdog on the APB access phase.

Parameters:
dataWidth, 32, AXI/APB data width (multiple of 8)
addrWidth, 32, AXI/APB address width
TIMEOUT_CYCLES, 16, max ACCESS-phase cycles waiting for pready; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
awvalid  in  1  write address valid
awaddr  in  addrWidth  write address
awprot  in  3  write protection
awready  out  1  write address ready
wvalid  in  1  write data valid
wdata  in  dataWidth  write data
wstrb  in  dataWidth/8  write strobes
wready  out  1  write data ready
bvalid  out  1  write response valid
bresp  out  2  write response
bready  in  1  write response ready
arvalid  in  1  read address valid
araddr  in  addrWidth  read address
arprot  in  3  read protection
arready  out  1  read address ready
rvalid  out  1  read data valid
rdata  out  dataWidth  read data
rresp  out  2  read response
rready  in  1  read data ready
paddr  out  addrWidth  APB address
pprot  out  3  APB protection
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  dataWidth  APB write data
pstrb  out  dataWidth/8  APB write strobes
prdata  in  dataWidth  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Clock clk; reset rst is asynchronous, active-low. On reset: state IDLE; all ready/valid outputs, psel, penable, pwrite = 0; paddr, pprot, pwdata, pstrb, rdata = 0; bresp, rresp = 2'b00; watchdog = 0.
- FSM states: IDLE, WDATA, SETUP, ACCESS, RESP. awready/arready/wready/bvalid/rvalid/psel/penable are Moore decodes of the state register.
- IDLE: awready=1; arready=!awvalid (write wins on a simultaneous request). aw handshake: latch paddr<=awaddr, pprot<=awprot, pwrite<=1, go to WDATA. ar handshake: latch paddr<=araddr, pprot<=arprot, pwrite<=0, pstrb<=0, go to SETUP.
- WDATA: wready=1. Waits indefinitely for wvalid; on handshake latch pwdata<=wdata, pstrb<=wstrb, go to SETUP. W is never accepted before AW.
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata/pstrb stay stable throughout. Watchdog clears on entry and increments each cycle with pready=0.
  - pready=1: resp<=pslverr ? 2'b10 : 2'b00; on reads rdata<=prdata. Go to RESP.
  - Watchdog reaches TIMEOUT_CYCLES (nonzero) with pready=0: abort, resp<=2'b10, rdata<=0 on reads. Go to RESP; psel drops next cycle.
- RESP: bvalid=1 (write) or rvalid=1 (read), with bresp/rresp and rdata stable until bready/rready. Handshake -> IDLE. The non-active response channel stays 0.
- Latency with pready=1 in the first ACCESS cycle and aw at cycle 0:
  - Write, wvalid at cycle 1: SETUP cycle 2, ACCESS cycle 3, bvalid cycle 4.
  - Read, ar at cycle 0: SETUP cycle 1, ACCESS cycle 2, rvalid cycle 3.
- rdata holds its last read value across writes.
- Reset mid-transaction: immediate return to IDLE with reset values. psel drops asynchronously, and the pending response is lost.

Decomposition:
- Shared package axi_apb_pkg: state enum type; RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- One sub-module, apb_watchdog: clear/enable inputs, expired output, width $clog2(TIMEOUT_CYCLES+1), held inert when TIMEOUT_CYCLES=0.

Test Plan:
- Write: awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF, pready=1, pslverr=0 -> SETUP at cycle 2 with psel=1, penable=0, pwrite=1, pstrb=0xF; bvalid=1, bresp=00 at cycle 4.
- Read: araddr=0x20, prdata=0x12345678, pready after 3 wait cycles -> penable held for 4 cycles, pstrb=0; rvalid=1, rdata=0x12345678, rresp=00.
- awvalid and arvalid both high in IDLE -> arready=0, write completes first; read is accepted only after the bready handshake.
- pslverr=1 on a read -> rresp=2'b10, rdata=prdata; bready held low 5 cycles on a write -> bvalid and bresp stable, no new APB transfer starts.
- TIMEOUT_CYCLES=16, pready held 0 -> exactly 16 ACCESS cycles, psel=0 afterwards, bresp=2'b10; repeat with TIMEOUT_CYCLES=0 -> waits indefinitely.
- rst asserted during ACCESS -> psel, penable, bvalid, rvalid = 0 immediately; the next read after reset completes normally.
